// File: rtl/execute_stage_if.sv
`default_nettype none
// ============================================================================
// Module  : execute_stage_if
// Purpose : Bundles the DEBuffer -> execute stage signal set and the execute
//           stage results into a single interface.
// Ports   : master modport - DEBuffer/pipeline side (drives *_i, reads *_o)
//           slave  modport - execute stage (reads *_i, drives *_o)
// Revision: 1.0 - initial release
// ============================================================================
interface execute_stage_if;
  // decode/execute buffer outputs
  logic        regDst_i;
  logic [1:0]  branchType_i;
  logic        jump_i;
  logic [3:0]  aluOp_i;
  logic        aluSrcA_i;
  logic        aluSrcB_i;
  logic [31:0] nextInstrAddr_i;
  logic [31:0] rsData_i;
  logic [31:0] rtData_i;
  logic [31:0] signExtend_i;
  logic [4:0]  rtAddr_i;
  logic [4:0]  rdAddr_i;
  logic [5:0]  funct_i;
  logic [4:0]  shamt_i;
  logic [25:0] jumpAddr_i;
  // execute stage results
  logic [31:0] aluResult_o;
  logic        zero_o;
  logic [4:0]  writeRegAddr_o;
  logic        branchTaken_o;
  logic [31:0] branchTarget_o;
  logic [31:0] jumpTarget_o;
  logic        stall_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  modport master (
    output regDst_i, branchType_i, jump_i, aluOp_i, aluSrcA_i, aluSrcB_i,
           nextInstrAddr_i, rsData_i, rtData_i, signExtend_i, rtAddr_i,
           rdAddr_i, funct_i, shamt_i, jumpAddr_i,
    input  aluResult_o, zero_o, writeRegAddr_o, branchTaken_o,
           branchTarget_o, jumpTarget_o, stall_o, hi_o, lo_o
  );

  modport slave (
    input  regDst_i, branchType_i, jump_i, aluOp_i, aluSrcA_i, aluSrcB_i,
           nextInstrAddr_i, rsData_i, rtData_i, signExtend_i, rtAddr_i,
           rdAddr_i, funct_i, shamt_i, jumpAddr_i,
    output aluResult_o, zero_o, writeRegAddr_o, branchTaken_o,
           branchTarget_o, jumpTarget_o, stall_o, hi_o, lo_o
  );
endinterface
`default_nettype wire

// File: rtl/execute_stage.sv
`default_nettype none
// ============================================================================
// Module  : execute_stage
// Purpose : MIPS execute stage: ALU, destination select, branch/jump targets,
//           HI/LO registers and an iterative shift-add multiplier that stalls
//           the upstream pipeline while it runs.
// Ports   : clk_i   - clock, rising edge
//           rst_n_i - synchronous active-low reset
//           bus     - execute_stage_if.slave (operands/controls in, results,
//                     stall and HI/LO observation out)
// Options : EXECUTE_STAGE_DIV_EN - adds div/divu (restoring division) on the
//           same iterative engine.
// Revision: 1.0 - initial release
// ============================================================================
module execute_stage #(
  parameter int MUL_CYCLES = 32,
  parameter int CNT_W      = $clog2(MUL_CYCLES) + 1
) (
  input  wire logic      clk_i,
  input  wire logic      rst_n_i,
  execute_stage_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [31:0]       r_hi, r_lo;
  logic [63:0]       r_prod;     // {acc/remainder, multiplier/dividend}
  logic [31:0]       r_mcand;    // multiplicand or divisor magnitude
  logic [CNT_W-1:0]  r_cnt;
  logic              r_neg_lo;

  logic [31:0] w_a, w_b, w_alu, w_sra;
  logic [3:0]  w_op;
  logic        w_sel_hi, w_sel_lo, w_stall;
  logic        w_is_rtype, w_is_mul, w_is_div, w_start, w_signed, w_last;
  logic [31:0] w_rs_mag, w_rt_mag;
  logic [32:0] w_sum;
  logic [63:0] w_mul_step, w_step, w_mul_fin;
  logic [31:0] w_hi_fin, w_lo_fin;

  assign w_a = bus.aluSrcA_i ? {27'b0, bus.shamt_i} : bus.rsData_i;
  assign w_b = bus.aluSrcB_i ? bus.signExtend_i : bus.rtData_i;
  assign w_sra = $signed(w_b) >>> w_a[4:0];

  assign w_is_rtype = (bus.aluOp_i == 4'b1111);
  assign w_is_mul   = w_is_rtype & ((bus.funct_i == 6'h18) | (bus.funct_i == 6'h19));
  // even funct (mult/div) is the signed flavour
  assign w_signed   = ~bus.funct_i[0];
  assign w_rs_mag   = (w_signed & bus.rsData_i[31]) ? (32'd0 - bus.rsData_i) : bus.rsData_i;
  assign w_rt_mag   = (w_signed & bus.rtData_i[31]) ? (32'd0 - bus.rtData_i) : bus.rtData_i;
  assign w_last     = (r_cnt == CNT_W'(MUL_CYCLES - 1));

  // R-type funct folds onto the aluOp encoding so one ALU case serves both
  always_comb begin
    w_op     = bus.aluOp_i;
    w_sel_hi = 1'b0;
    w_sel_lo = 1'b0;
    if (w_is_rtype) begin
      case (bus.funct_i)
        6'h20, 6'h21: w_op = 4'b0000;
        6'h22, 6'h23: w_op = 4'b0001;
        6'h24:        w_op = 4'b0010;
        6'h25:        w_op = 4'b0011;
        6'h26:        w_op = 4'b0100;
        6'h27:        w_op = 4'b0101;
        6'h2A:        w_op = 4'b0110;
        6'h2B:        w_op = 4'b0111;
        6'h00, 6'h04: w_op = 4'b1000;
        6'h02, 6'h06: w_op = 4'b1001;
        6'h03, 6'h07: w_op = 4'b1010;
        6'h10:        w_sel_hi = 1'b1;
        6'h12:        w_sel_lo = 1'b1;
        default:      w_op = 4'b1111;   // mult/div/unknown read as 0
      endcase
    end
  end

  always_comb begin
    w_alu = '0;
    case (w_op)
      4'b0000: w_alu = w_a + w_b;
      4'b0001: w_alu = w_a - w_b;
      4'b0010: w_alu = w_a & w_b;
      4'b0011: w_alu = w_a | w_b;
      4'b0100: w_alu = w_a ^ w_b;
      4'b0101: w_alu = ~(w_a | w_b);
      4'b0110: w_alu = {31'b0, $signed(w_a) < $signed(w_b)};
      4'b0111: w_alu = {31'b0, w_a < w_b};
      4'b1000: w_alu = w_b << w_a[4:0];
      4'b1001: w_alu = w_b >> w_a[4:0];
      4'b1010: w_alu = w_sra;
      4'b1011: w_alu = {w_b[15:0], 16'h0000};
      default: w_alu = '0;
    endcase
    if (w_sel_hi) w_alu = r_hi;
    if (w_sel_lo) w_alu = r_lo;
  end

  // shift-add multiply step: conditional add into the upper half, shift right
  assign w_sum      = {1'b0, r_prod[63:32]} + (r_prod[0] ? {1'b0, r_mcand} : 33'd0);
  assign w_mul_step = {w_sum, r_prod[31:1]};
  assign w_mul_fin  = r_neg_lo ? (64'd0 - w_mul_step) : w_mul_step;

`ifdef EXECUTE_STAGE_DIV_EN
  logic        r_is_div, r_neg_hi;
  logic [32:0] w_shift;
  logic        w_ge;
  logic [31:0] w_rem;
  logic [63:0] w_div_step;

  assign w_is_div = w_is_rtype & ((bus.funct_i == 6'h1A) | (bus.funct_i == 6'h1B));
  // restoring step; a zero divisor naturally yields q = all ones, r = dividend
  assign w_shift    = {r_prod[63:32], r_prod[31]};
  assign w_ge       = (w_shift >= {1'b0, r_mcand});
  assign w_rem      = w_ge ? 32'(w_shift - {1'b0, r_mcand}) : w_shift[31:0];
  assign w_div_step = {w_rem, r_prod[30:0], w_ge};
  assign w_step     = r_is_div ? w_div_step : w_mul_step;
  assign w_hi_fin   = r_is_div ? (r_neg_hi ? (32'd0 - w_div_step[63:32]) : w_div_step[63:32])
                               : w_mul_fin[63:32];
  assign w_lo_fin   = r_is_div ? (r_neg_lo ? (32'd0 - w_div_step[31:0]) : w_div_step[31:0])
                               : w_mul_fin[31:0];
`else
  assign w_is_div = 1'b0;
  assign w_step   = w_mul_step;
  assign w_hi_fin = w_mul_fin[63:32];
  assign w_lo_fin = w_mul_fin[31:0];
`endif

  assign w_start = w_is_mul | w_is_div;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // DONE never looks at start, so the instruction still held there cannot re-fire
  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    case (r_state)
      S_IDLE: if (w_start) begin
        w_stall     = 1'b1;
        w_state_nxt = S_BUSY;
      end
      S_BUSY: begin
        w_stall = 1'b1;
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_hi     <= '0;
      r_lo     <= '0;
      r_prod   <= '0;
      r_mcand  <= '0;
      r_cnt    <= '0;
      r_neg_lo <= 1'b0;
`ifdef EXECUTE_STAGE_DIV_EN
      r_is_div <= 1'b0;
      r_neg_hi <= 1'b0;
`endif
    end else if (r_state == S_IDLE && w_start) begin
      r_prod   <= {32'd0, w_rs_mag};
      r_mcand  <= w_rt_mag;
      r_cnt    <= '0;
      r_neg_lo <= w_signed & (bus.rsData_i[31] ^ bus.rtData_i[31]);
`ifdef EXECUTE_STAGE_DIV_EN
      r_is_div <= w_is_div;
      r_neg_hi <= w_signed & (w_is_div ? bus.rsData_i[31]
                                       : (bus.rsData_i[31] ^ bus.rtData_i[31]));
`endif
    end else if (r_state == S_BUSY) begin
      r_prod <= w_step;
      r_cnt  <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_hi <= w_hi_fin;
        r_lo <= w_lo_fin;
      end
    end
  end

  assign bus.aluResult_o    = w_alu;
  assign bus.zero_o         = ((bus.rsData_i - bus.rtData_i) == 32'd0);
  assign bus.writeRegAddr_o = bus.regDst_i ? bus.rdAddr_i : bus.rtAddr_i;
  assign bus.branchTaken_o  = ((bus.branchType_i == 2'b01) &  bus.zero_o) |
                              ((bus.branchType_i == 2'b10) & ~bus.zero_o);
  assign bus.branchTarget_o = bus.nextInstrAddr_i + {bus.signExtend_i[29:0], 2'b00};
  assign bus.jumpTarget_o   = {bus.nextInstrAddr_i[31:28], bus.jumpAddr_i, 2'b00};
  assign bus.stall_o        = rst_n_i & w_stall;
  assign bus.hi_o           = r_hi;
  assign bus.lo_o           = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_execute_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_execute_stage
// Purpose : Self-checking bench for execute_stage: directed cases plus
//           randomized ALU and multiply/divide traffic against a reference
//           model built from instruction semantics.
// Revision: 1.0 - initial release
// ============================================================================
module tb_execute_stage;
  logic clk_i = 1'b0;
  logic rst_n_i = 1'b0;
  always #5 clk_i = ~clk_i;

  execute_stage_if bus ();
  execute_stage dut (.clk_i(clk_i), .rst_n_i(rst_n_i), .bus(bus));

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // instruction-level meaning of each ALU/R-type operation
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [5:0] f,
                                          input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] hi, input logic [31:0] lo);
    logic [3:0] k;
    logic [4:0] sh;
    int sa, sb;
    sh = a[4:0];
    sa = a;
    sb = b;
    k  = op;
    if (op == 4'hF) begin
      case (f)
        6'h20, 6'h21: k = 4'd0;
        6'h22, 6'h23: k = 4'd1;
        6'h24: k = 4'd2;
        6'h25: k = 4'd3;
        6'h26: k = 4'd4;
        6'h27: k = 4'd5;
        6'h2A: k = 4'd6;
        6'h2B: k = 4'd7;
        6'h00, 6'h04: k = 4'd8;
        6'h02, 6'h06: k = 4'd9;
        6'h03, 6'h07: k = 4'd10;
        6'h10: return hi;
        6'h12: return lo;
        default: return 32'd0;
      endcase
    end
    case (k)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return ~(a | b);
      4'd6:  return {31'b0, sa < sb};
      4'd7:  return {31'b0, a < b};
      4'd8:  return b << sh;
      4'd9:  return b >> sh;
      4'd10: return (b >> sh) | (b[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
      4'd11: return b * 32'd65536;
      default: return 32'd0;
    endcase
  endfunction

  task automatic clear_inputs();
    bus.regDst_i = 1'b0; bus.branchType_i = 2'b00; bus.jump_i = 1'b0;
    bus.aluOp_i = 4'b0000; bus.aluSrcA_i = 1'b0; bus.aluSrcB_i = 1'b0;
    bus.nextInstrAddr_i = 32'd0; bus.rsData_i = 32'd0; bus.rtData_i = 32'd0;
    bus.signExtend_i = 32'd0; bus.rtAddr_i = 5'd0; bus.rdAddr_i = 5'd0;
    bus.funct_i = 6'd0; bus.shamt_i = 5'd0; bus.jumpAddr_i = 26'd0;
  endtask

  task automatic set_rtype(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt);
    clear_inputs();
    bus.aluOp_i = 4'hF; bus.funct_i = f; bus.rsData_i = rs; bus.rtData_i = rt;
  endtask

  task automatic random_alu();
    logic [31:0] a, b, exp_bt;
    logic        z, exp_tk;
    logic [5:0]  f;
    bus.regDst_i = 1'($urandom); bus.branchType_i = 2'($urandom);
    bus.jump_i = 1'($urandom); bus.aluOp_i = 4'($urandom);
    bus.aluSrcA_i = 1'($urandom); bus.aluSrcB_i = 1'($urandom);
    bus.nextInstrAddr_i = $urandom; bus.rsData_i = $urandom;
    bus.rtData_i = ($urandom_range(0, 3) == 0) ? bus.rsData_i : $urandom;
    bus.signExtend_i = $urandom; bus.rtAddr_i = 5'($urandom);
    bus.rdAddr_i = 5'($urandom); bus.shamt_i = 5'($urandom);
    bus.jumpAddr_i = 26'($urandom);
    f = 6'($urandom);
    if (f == 6'h18 || f == 6'h19) f = 6'h20;
`ifdef EXECUTE_STAGE_DIV_EN
    if (f == 6'h1A || f == 6'h1B) f = 6'h12;
`endif
    if ($urandom_range(0, 2) == 0) f = 6'h10 | 6'($urandom_range(0, 1) * 2);
    bus.funct_i = f;
    #1;
    a = bus.aluSrcA_i ? {27'b0, bus.shamt_i} : bus.rsData_i;
    b = bus.aluSrcB_i ? bus.signExtend_i : bus.rtData_i;
    z = (bus.rsData_i == bus.rtData_i);
    exp_tk = (bus.branchType_i == 2'd1 && z) || (bus.branchType_i == 2'd2 && !z);
    exp_bt = bus.nextInstrAddr_i + bus.signExtend_i * 32'd4;
    check("rnd_alu", bus.aluResult_o, ref_alu(bus.aluOp_i, f, a, b, m_hi, m_lo));
    check("rnd_zero", 32'(bus.zero_o), 32'(z));
    check("rnd_wreg", 32'(bus.writeRegAddr_o), 32'(bus.regDst_i ? bus.rdAddr_i : bus.rtAddr_i));
    check("rnd_taken", 32'(bus.branchTaken_o), 32'(exp_tk));
    check("rnd_btgt", bus.branchTarget_o, exp_bt);
    check("rnd_jtgt", bus.jumpTarget_o, {bus.nextInstrAddr_i[31:28], bus.jumpAddr_i, 2'b00});
    check("rnd_stall", 32'(bus.stall_o), 32'd0);
  endtask

  // multiply/divide: expectations come from full-width arithmetic
  task automatic run_muldiv(input string tag, input logic [5:0] f,
                            input logic [31:0] rs, input logic [31:0] rt);
    logic signed [63:0] sx, sy;
    logic [63:0] p;
    logic [31:0] ma, mb, q, r, eh, el;
    logic        sgn;
    int n;
    sgn = ~f[0];
    if (f == 6'h18) begin
      sx = $signed(rs); sy = $signed(rt); p = sx * sy;
      eh = p[63:32]; el = p[31:0];
    end else if (f == 6'h19) begin
      p = {32'd0, rs} * {32'd0, rt};
      eh = p[63:32]; el = p[31:0];
    end else begin
      ma = (sgn && rs[31]) ? -rs : rs;
      mb = (sgn && rt[31]) ? -rt : rt;
      if (mb == 32'd0) begin q = 32'hFFFF_FFFF; r = ma; end
      else begin q = ma / mb; r = ma % mb; end
      if (sgn && (rs[31] ^ rt[31])) q = -q;
      if (sgn && rs[31]) r = -r;
      eh = r; el = q;
    end
    @(negedge clk_i);
    set_rtype(f, rs, rt);
    #1;
    n = 0;
    while (bus.stall_o === 1'b1 && n < 100) begin
      n++;
      @(negedge clk_i);
      #1;
    end
    check({tag, "_stall_len"}, 32'(n), 32'd33);
    check({tag, "_hi"}, bus.hi_o, eh);
    check({tag, "_lo"}, bus.lo_o, el);
    m_hi = eh;
    m_lo = el;
    @(negedge clk_i);
    set_rtype(6'h12, 32'd0, 32'd0);
    #1;
    check({tag, "_mflo"}, bus.aluResult_o, el);
    check({tag, "_mflo_stall"}, 32'(bus.stall_o), 32'd0);
    bus.funct_i = 6'h10;
    #1;
    check({tag, "_mfhi"}, bus.aluResult_o, eh);
    @(negedge clk_i);
    #1;
    check({tag, "_after_stall"}, 32'(bus.stall_o), 32'd0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    rst_n_i = 1'b0;
    repeat (2) @(negedge clk_i);
    set_rtype(6'h18, 32'd3, 32'd4);
    #1;
    check("rst_stall_forced", 32'(bus.stall_o), 32'd0);
    check("rst_hi", bus.hi_o, 32'd0);
    check("rst_lo", bus.lo_o, 32'd0);
    @(negedge clk_i);
    clear_inputs();
    rst_n_i = 1'b1;
    #1;
    check("post_rst_stall", 32'(bus.stall_o), 32'd0);

    // directed combinational cases
    @(negedge clk_i);
    set_rtype(6'h20, 32'h7FFF_FFFF, 32'd1);
    bus.regDst_i = 1'b1; bus.rdAddr_i = 5'd13; bus.rtAddr_i = 5'd7;
    #1;
    check("add_wrap", bus.aluResult_o, 32'h8000_0000);
    check("add_wreg", 32'(bus.writeRegAddr_o), 32'd13);
    set_rtype(6'h03, 32'd0, 32'hF000_0000);
    bus.aluSrcA_i = 1'b1; bus.shamt_i = 5'd4;
    #1;
    check("sra", bus.aluResult_o, 32'hFF00_0000);
    set_rtype(6'h2A, 32'hFFFF_FFFF, 32'd1);
    #1;
    check("slt", bus.aluResult_o, 32'd1);
    bus.funct_i = 6'h2B;
    #1;
    check("sltu", bus.aluResult_o, 32'd0);
    clear_inputs();
    bus.aluOp_i = 4'b0001; bus.branchType_i = 2'b01;
    bus.rsData_i = 32'd5; bus.rtData_i = 32'd5;
    bus.nextInstrAddr_i = 32'h100; bus.signExtend_i = 32'hFFFF_FFFE;
    #1;
    check("beq_taken", 32'(bus.branchTaken_o), 32'd1);
    check("beq_target", bus.branchTarget_o, 32'h0000_00F8);
    bus.branchType_i = 2'b10;
    #1;
    check("bne_taken", 32'(bus.branchTaken_o), 32'd0);

    // directed multiply
    run_muldiv("mult_neg3x7", 6'h18, 32'hFFFF_FFFD, 32'd7);
    check("mult_hi_const", bus.hi_o, 32'hFFFF_FFFF);
    check("mult_lo_const", bus.lo_o, 32'hFFFF_FFEB);
    run_muldiv("multu_max", 6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_hi_const", bus.hi_o, 32'hFFFF_FFFE);
    check("multu_lo_const", bus.lo_o, 32'h0000_0001);

`ifdef EXECUTE_STAGE_DIV_EN
    run_muldiv("div_m7_2", 6'h1A, 32'hFFFF_FFF9, 32'd2);
    check("div_lo_const", bus.lo_o, 32'hFFFF_FFFD);
    check("div_hi_const", bus.hi_o, 32'hFFFF_FFFF);
    run_muldiv("div_by0", 6'h1A, 32'hFFFF_FFF9, 32'd0);
    run_muldiv("divu_by0", 6'h1B, 32'h1234_5678, 32'd0);
    for (int i = 0; i < 4; i++) begin
      run_muldiv("rnd_div", 6'h1A, $urandom, $urandom_range(0, 1) ? $urandom : 32'($urandom_range(1, 9)));
      run_muldiv("rnd_divu", 6'h1B, $urandom, $urandom);
    end
`else
    // without the divider, div/divu are plain no-ops
    @(negedge clk_i);
    set_rtype(6'h1A, 32'd100, 32'd7);
    #1;
    check("div_off_result", bus.aluResult_o, 32'd0);
    check("div_off_stall", 32'(bus.stall_o), 32'd0);
    @(negedge clk_i);
    bus.funct_i = 6'h1B;
    #1;
    check("divu_off_stall", 32'(bus.stall_o), 32'd0);
    check("div_off_hi", bus.hi_o, m_hi);
    check("div_off_lo", bus.lo_o, m_lo);
`endif

    for (int i = 0; i < 3; i++) begin
      run_muldiv("rnd_mult", 6'h18, $urandom, $urandom);
      run_muldiv("rnd_multu", 6'h19, $urandom, $urandom);
    end

    for (int i = 0; i < 150; i++) begin
      @(negedge clk_i);
      random_alu();
    end

    // reset while BUSY, counter at 10
    @(negedge clk_i);
    set_rtype(6'h18, 32'h0001_2345, 32'h0000_6789);
    repeat (11) @(negedge clk_i);
    #1;
    check("busy_before_rst", 32'(bus.stall_o), 32'd1);
    rst_n_i = 1'b0;
    #1;
    check("busy_rst_forced", 32'(bus.stall_o), 32'd0);
    @(negedge clk_i);
    clear_inputs();
    rst_n_i = 1'b1;
    #1;
    check("abort_stall", 32'(bus.stall_o), 32'd0);
    check("abort_hi", bus.hi_o, 32'd0);
    check("abort_lo", bus.lo_o, 32'd0);
    m_hi = 32'd0;
    m_lo = 32'd0;
    @(negedge clk_i);
    #1;
    check("abort_idle", 32'(bus.stall_o), 32'd0);

    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      random_alu();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Execute stage of the 5-stage MIPS datapath. Sits directly downstream of the Decode/Execute buffer (DEBuffer) and consumes all of its outputs.
- Computes the ALU result, the destination register address, branch decision/target and jump target.
- Owns the HI/LO registers and an iterative 32-cycle multiplier.
- Raises stall_o to freeze PC, IF/ID and DEBuffer while a multiply is in flight.

Parameters:
- MUL_CYCLES, 32, iterations of the shift-add multiplier. Also sets the width of the iteration counter: log2, 6 bits.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- rst_n_i  in  1  synchronous active-low reset
- regDst_i  in  1  1: write address = rdAddr_i; 0: rtAddr_i
- branchType_i  in  2  00 none, 01 beq, 10 bne, 11 none
- jump_i  in  1  jump instruction
- aluOp_i  in  4  ALU operation; 1111 = R-type, decode funct_i
- aluSrcA_i  in  1  1: A = {27'b0, shamt_i}; 0: A = rsData_i
- aluSrcB_i  in  1  1: B = signExtend_i; 0: B = rtData_i
- nextInstrAddr_i  in  32  PC+4
- rsData_i, rtData_i, signExtend_i  in  32 each  operands
- rtAddr_i, rdAddr_i  in  5 each  register addresses
- funct_i  in  6  R-type function
- shamt_i  in  5  shift amount
- jumpAddr_i  in  26  jump index
- aluResult_o  out  32  ALU/mfhi/mflo result, combinational
- zero_o  out  1  (rsData_i - rtData_i) == 0
- writeRegAddr_o  out  5  selected destination
- branchTaken_o  out  1  (01 & zero_o) | (10 & ~zero_o)
- branchTarget_o  out  32  nextInstrAddr_i + (signExtend_i << 2)
- jumpTarget_o  out  32  {nextInstrAddr_i[31:28], jumpAddr_i, 2'b00}
- stall_o  out  1  hold all upstream stages this cycle
- hi_o, lo_o  out  32 each  registered HI/LO (debug/observation)

Behaviour:
- aluOp encodings:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 NOR
  - 0110 SLT (signed), 0111 SLTU
  - 1000 SLL, 1001 SRL, 1010 SRA: result = B shifted by A[4:0]
  - 1011 LUI: B << 16
  - other codes: result 0
- R-type funct decode:
  - 20/21 add, 22/23 sub, 24 and, 25 or, 26 xor, 27 nor, 2A slt, 2B sltu
  - 00 sll, 02 srl, 03 sra (aluSrcA_i = 1); 04 sllv, 06 srlv, 07 srav (A = rs)
  - 10 mfhi, 12 mflo
  - 18 mult, 19 multu; result 0 for these
  - other funct: result 0
- No overflow trap; all adds/subs wrap modulo 2^32.
- Reset (rst_n_i low at an edge): state IDLE, HI = LO = 0, counter = 0. stall_o is forced 0 combinationally while rst_n_i is low.
- Multiply FSM states: IDLE, BUSY, DONE.
  - IDLE: start = (aluOp_i == 1111) & (funct_i == 18 or 19). On start, stall_o = 1 that cycle; latch |rs|, |rt| and the result sign (signed only); counter = 0; go to BUSY.
  - BUSY: stall_o = 1. One shift-add step per cycle. At counter == MUL_CYCLES-1, write {HI, LO} (negated if the sign flag is set) and go to DONE.
  - DONE: stall_o = 0. Start is suppressed so the same held instruction does not restart. Go to IDLE.
- Latency: stall_o is high for 33 cycles (detect + 32 BUSY). HI/LO are visible on the cycle DONE is entered, so an mfhi/mflo immediately following the multiply reads the new value.
- Reset mid-BUSY: aborts the multiply, zeroes HI/LO, state IDLE on the next cycle.
- All outputs other than stall_o, hi_o and lo_o are pure functions of the current inputs and HI/LO.

Optional Feature:
- Macro: EXECUTE_STAGE_DIV_EN.
- Defined: funct 1A div / 1B divu start the same FSM using restoring division over 32 cycles. LO = quotient, HI = remainder. Signed: quotient sign = sign(rs) xor sign(rt); remainder takes the sign of rs. Divide by zero (unsigned magnitudes): LO = FFFFFFFF, HI = |rs|, then sign fix applied.
- Not defined: 1A/1B give result 0, no stall, HI/LO unchanged.

Test Plan:
- R-type add, rs = 7FFFFFFF, rt = 1 -> aluResult_o = 80000000; writeRegAddr_o = rdAddr_i with regDst_i = 1.
- sra, aluSrcA_i = 1, shamt = 4, rt = F0000000 -> 0xFF000000. slt with rs = FFFFFFFF, rt = 1 -> 1. sltu, same operands -> 0.
- beq, rs = rt = 5, nextInstrAddr = 100, signExtend = FFFFFFFE -> branchTaken_o = 1, branchTarget_o = 0xF8. Same inputs with bne -> branchTaken_o = 0.
- mult, rs = FFFFFFFD (-3), rt = 7 -> stall_o high exactly 33 cycles. Then HI = FFFFFFFF, LO = FFFFFFEB. Following mflo -> FFFFFFEB with no extra stall.
- multu, rs = rt = FFFFFFFF -> HI = FFFFFFFE, LO = 00000001.
- rst_n_i low at BUSY cycle 10 of a mult -> next cycle state IDLE, stall_o = 0, HI = LO = 0. With EXECUTE_STAGE_DIV_EN: div, rs = -7, rt = 2 -> LO = FFFFFFFD, HI = FFFFFFFF.
